// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I integer ALU (OP / OP-IMM) with a registered, back-pressurable result.
// Define ALU_MULDIV_EN to compile in the iterative M-extension multiply/divide unit (CALC state).
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            alu_sel,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
        CALC = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state_r;

    logic [XLEN-1:0] alu_res_s;
    logic            alu_ill_s;
    logic            md_sel_s;
    logic            f7_zero_s;
    logic            f7_alt_s;
    logic            lt_s;
    logic            ltu_s;
    logic [SHW-1:0]  shamt_s;

    assign f7_zero_s = (funct7 == 7'h00);
    assign f7_alt_s  = (funct7 == 7'h20);
    assign lt_s      = ($signed(x) < $signed(y));
    assign ltu_s     = (x < y);
    assign shamt_s   = y[SHW-1:0];

`ifdef ALU_MULDIV_EN
    assign md_sel_s = !alu_sel && (funct7 == 7'h01);
`else
    assign md_sel_s = 1'b0;
`endif

    // Single-cycle decode; immediate forms only check funct7 on shifts, ADDI ignores it entirely.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b0;
        case (funct3)
            3'b000: begin
                if (alu_sel || f7_zero_s) begin
                    alu_res_s = x + y;
                end else if (f7_alt_s) begin
                    alu_res_s = x - y;
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b001: begin
                if (f7_zero_s) begin
                    alu_res_s = x << shamt_s;
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b010: begin
                if (alu_sel || f7_zero_s) begin
                    alu_res_s = {{(XLEN-1){1'b0}}, lt_s};
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b011: begin
                if (alu_sel || f7_zero_s) begin
                    alu_res_s = {{(XLEN-1){1'b0}}, ltu_s};
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b100: begin
                if (alu_sel || f7_zero_s) begin
                    alu_res_s = x ^ y;
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b101: begin
                if (f7_zero_s) begin
                    alu_res_s = x >> shamt_s;
                end else if (f7_alt_s) begin
                    alu_res_s = $signed(x) >>> shamt_s;
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b110: begin
                if (alu_sel || f7_zero_s) begin
                    alu_res_s = x | y;
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            3'b111: begin
                if (alu_sel || f7_zero_s) begin
                    alu_res_s = x & y;
                end else begin
                    alu_ill_s = 1'b1;
                end
            end
            default: begin
                alu_ill_s = 1'b1;
            end
        endcase
    end

`ifdef ALU_MULDIV_EN
    // Shared iteration registers: multiply uses {hi,lo} as accumulator/multiplier,
    // divide uses hi as partial remainder and lo as dividend/quotient.
    logic [SHW-1:0]      cnt_r;
    logic [2:0]          op_r;
    logic [XLEN:0]       hi_r;
    logic [XLEN-1:0]     lo_r;
    logic [XLEN-1:0]     b_r;
    logic                neg_r;
    logic                neg_rem_r;
    logic                dz_r;

    logic                sx_s;
    logic                sy_s;
    logic [XLEN-1:0]     mag_x_s;
    logic [XLEN-1:0]     mag_y_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       shl_s;
    logic [XLEN:0]       trial_s;
    logic [XLEN:0]       hi_nxt_s;
    logic [XLEN-1:0]     lo_nxt_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     q_s;
    logic [XLEN-1:0]     r_s;
    logic [XLEN-1:0]     md_res_s;

    assign sx_s    = x[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                                   (funct3 == 3'b100) || (funct3 == 3'b110));
    assign sy_s    = y[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                                   (funct3 == 3'b110));
    assign mag_x_s = sx_s ? ({XLEN{1'b0}} - x) : x;
    assign mag_y_s = sy_s ? ({XLEN{1'b0}} - y) : y;

    // One shift-add or restoring-divide step per CALC cycle.
    always_comb begin
        sum_s    = hi_r + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        shl_s    = {hi_r[XLEN-1:0], lo_r[XLEN-1]};
        trial_s  = shl_s - {1'b0, b_r};
        hi_nxt_s = {(XLEN+1){1'b0}};
        lo_nxt_s = {XLEN{1'b0}};
        if (op_r[2]) begin
            if (trial_s[XLEN]) begin
                hi_nxt_s = shl_s;
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
            end else begin
                hi_nxt_s = trial_s;
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_nxt_s = {1'b0, sum_s[XLEN:1]};
            lo_nxt_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the final step's values; divide-by-zero overrides the quotient.
    always_comb begin
        prod_s     = {hi_nxt_s[XLEN-1:0], lo_nxt_s};
        prod_fix_s = neg_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        q_s        = dz_r ? {XLEN{1'b1}} : (neg_r ? ({XLEN{1'b0}} - lo_nxt_s) : lo_nxt_s);
        r_s        = neg_rem_r ? ({XLEN{1'b0}} - hi_nxt_s[XLEN-1:0]) : hi_nxt_s[XLEN-1:0];
        md_res_s   = {XLEN{1'b0}};
        case (op_r)
            3'b000:                 md_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_res_s = q_s;
            3'b110, 3'b111:         md_res_s = r_s;
            default:                md_res_s = {XLEN{1'b0}};
        endcase
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            out       <= {XLEN{1'b0}};
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ALU_MULDIV_EN
            cnt_r     <= {SHW{1'b0}};
            op_r      <= 3'b000;
            hi_r      <= {(XLEN+1){1'b0}};
            lo_r      <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            neg_r     <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (md_sel_s) begin
`ifdef ALU_MULDIV_EN
                            state_r   <= CALC;
                            cnt_r     <= SHW'(XLEN-1);
                            op_r      <= funct3;
                            hi_r      <= {(XLEN+1){1'b0}};
                            lo_r      <= mag_x_s;
                            b_r       <= mag_y_s;
                            neg_r     <= sx_s ^ sy_s;
                            neg_rem_r <= sx_s;
                            dz_r      <= funct3[2] && (y == {XLEN{1'b0}});
`else
                            state_r   <= IDLE;
`endif
                        end else begin
                            state_r   <= DONE;
                            out       <= alu_res_s;
                            illegal   <= alu_ill_s;
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                CALC: begin
                    hi_r <= hi_nxt_s;
                    lo_r <= lo_nxt_s;
                    if (cnt_r == {SHW{1'b0}}) begin
                        state_r   <= DONE;
                        out       <= md_res_s;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(SHW-1){1'b0}}, 1'b1};
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle integer ALU in the RV32I execute stage. It accepts one operation per valid/ready transfer and decodes RISC-V funct3/funct7 for register and immediate forms with correct signed/unsigned semantics. It returns a registered result through an output valid/ready port that supports back-pressure. When the M-extension option is compiled in, it also runs iterative multiply/divide over XLEN cycles.

## Interface
- XLEN, 32, datapath width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount bits taken from y
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation
- funct3  input  3  RISC-V funct3
- funct7  input  7  RISC-V funct7; for immediate shifts, imm[11:5]
- alu_sel  input  1  1 = immediate form (OP-IMM), 0 = register form (OP)
- x  input  XLEN  rs1 operand
- y  input  XLEN  rs2 operand or sign-extended immediate
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out  output  XLEN  result
- illegal  output  1  qualifies out; unsupported funct3/funct7 combination

## Operation
- States: IDLE, CALC (only with muldiv), DONE. Reset state is IDLE.
- Reset values: out = 0, illegal = 0, out_valid = 0, in_ready = 1.
- in_ready = (state == IDLE). A transfer occurs on a clock edge where in_valid && in_ready. Inputs are captured only at that edge.
- Single-cycle ops go IDLE→DONE. out and illegal are written at the accept edge.
- DONE: out_valid = 1. out and illegal are held stable until out_valid && out_ready, then the block returns to IDLE.
- Immediate form (alu_sel = 1):
  - ADDI: x + y; funct7 is ignored.
  - SLTI: signed compare.
  - SLTIU: unsigned compare.
  - XORI, ORI, ANDI: bitwise.
  - SLLI: x << y[SHW-1:0].
  - SRLI / SRAI: selected by funct7[5], logical or arithmetic.
- Register form (alu_sel = 0):
  - ADD / SUB: selected by funct7[5].
  - SLL, SRL / SRA: shift amount y[SHW-1:0].
  - SLT: signed; SLTU: unsigned.
  - XOR, OR, AND.
- Compare results are zero-extended 1/0.
- Legal funct7 values: 0x00; 0x20 only for SUB, SRA and SRAI; 0x01 only when muldiv is enabled. Any other value, in either form where funct7 is checked, gives out = 0 and illegal = 1 and follows the single-cycle path.
- The result is never left unassigned: default out = 0.
- Muldiv ops (alu_sel = 0, funct7 = 0x01):
  - MUL, MULH, MULHSU, MULHU: radix-2 shift-add on operand magnitudes, 2·XLEN-bit product. The product is negated at completion if the result sign is negative. MUL returns the low half; the others return the high half.
  - DIV, DIVU, REM, REMU: restoring division on magnitudes. Signs are fixed at completion: quotient sign = sign(x) ^ sign(y); remainder sign = sign(x).
  - Divide by zero: quotient = all ones, remainder = x.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = x, remainder = 0.
- A counter runs from XLEN−1 down to 0 in CALC, one iteration per cycle. The result is written on the final iteration.

## Timing
- Single-cycle op accepted at edge T: out_valid is high after T. With out_ready = 1 the result is consumed at T+1, and in_ready is high again after T+1. Throughput is one op per 2 cycles.
- Muldiv op accepted at T: out_valid rises after edge T+XLEN. Latency is fixed, including the divide-by-zero and overflow cases.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset asserted in any state, including mid-CALC: outputs go to their reset values immediately, the counter is cleared, and the partial result is discarded.

## Configuration
- ALU_MULDIV_EN defined: the CALC state, counter, multiplier/divider datapath and funct7 = 0x01 decoding are compiled in.
- ALU_MULDIV_EN undefined: no CALC state. funct7 = 0x01 is illegal (out = 0, illegal = 1, single-cycle).

## Test plan
- Immediate compares and shifts, XLEN = 32:
  - SLTI x = 0xFFFFFFFF, y = 1 → out 1.
  - SLTIU same operands → out 0.
  - SRAI x = 0x80000000, y = 4, funct7 = 0x20 → out 0xF8000000, illegal 0.
- SUB x = 5, y = 7 → 0xFFFFFFFE. SLL x = 1, y = 0x21 → 2 (uses 5 LSBs). ADD with funct7 = 0x40 → out 0, illegal 1.
- Back-pressure: out_ready held low for 5 cycles after ADD 3 + 4 → out stays 7, out_valid stays 1, in_ready stays 0. The next in_valid is accepted only after the handshake.
- Muldiv, ALU_MULDIV_EN defined:
  - MULH 0x80000000 × 0x80000000 → 0x40000000 after 32 cycles.
  - DIV 7 / 0 → 0xFFFFFFFF.
  - REM 0x80000000 rem 0xFFFFFFFF → 0.
- Reset pulse low at cycle 10 of a DIVU → out_valid 0, in_ready 1 immediately. The next DIVU 100 / 7 returns 14 with the normal latency.
- ALU_MULDIV_EN undefined: MUL 3 × 4 → out 0, illegal 1, out_valid after 1 cycle.
